button_conditioner: RTL

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_conditioner.sv | 62 ++++++
 1 files changed

// File: rtl/button_conditioner.sv
// button_conditioner: synchronizes, debounces and optionally auto-repeats two pushbuttons into
// single-cycle duty step pulses; simultaneous pulses on both channels cancel each other.
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned REPEAT_EN       = 1,
    parameter int unsigned REPEAT_DELAY    = 20,
    parameter int unsigned REPEAT_RATE     = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_inc_raw,
    input  logic btn_dec_raw,
    output logic increase_duty,
    output logic decrease_duty
);
    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam int RW = $clog2(RMAX);
    logic [1:0] s1_q, s2_q, stable_q, stable_d, phase_q, phase_d, press, rep_hit, fire;
    logic [1:0][CW-1:0] cnt_q, cnt_d;
    logic [1:0][RW-1:0] rep_q, rep_d;
    logic inc_q, inc_d, dec_q, dec_d;
    // Index 0 is the increase channel, index 1 the decrease channel.
    // phase_q selects the repeat interval: 0 waits REPEAT_DELAY, 1 waits REPEAT_RATE.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            stable_d[i] = (s2_q[i] != stable_q[i] && cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) ? s2_q[i] : stable_q[i];
            cnt_d[i] = (s2_q[i] != stable_q[i] && cnt_q[i] != CW'(DEBOUNCE_CYCLES - 1)) ? cnt_q[i] + CW'(1) : '0;
            press[i] = stable_d[i] & ~stable_q[i];
            rep_hit[i] = REPEAT_EN != 0 && stable_q[i] && stable_d[i] &&
                         rep_q[i] == (phase_q[i] ? RW'(REPEAT_RATE - 1) : RW'(REPEAT_DELAY - 1));
            rep_d[i] = (REPEAT_EN == 0 || !stable_d[i] || press[i] || rep_hit[i]) ? '0 : rep_q[i] + RW'(1);
            phase_d[i] = stable_d[i] & ~press[i] & (phase_q[i] | rep_hit[i]);
            fire[i] = press[i] | rep_hit[i];
        end
        inc_d = fire[0] & ~fire[1];
        dec_d = fire[1] & ~fire[0];
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q     <= '0;
            s2_q     <= '0;
            stable_q <= '0;
            phase_q  <= '0;
            cnt_q    <= '0;
            rep_q    <= '0;
            inc_q    <= 1'b0;
            dec_q    <= 1'b0;
        end else begin
            s1_q     <= {btn_dec_raw, btn_inc_raw};
            s2_q     <= s1_q;
            stable_q <= stable_d;
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            rep_q    <= rep_d;
            inc_q    <= inc_d;
            dec_q    <= dec_d;
        end
    end
    assign increase_duty = inc_q;
    assign decrease_duty = dec_q;
endmodule
